// File: rtl/sp_32xn_ram.sv
// 32-word x DW-bit single-port register-file RAM: one shared address, synchronous
// write, read-first registered output, async active-low clear of all storage.
module sp_32xn_ram_word #(
  parameter int DW = 4
) (
  input  logic          wclk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] word_o
);
  logic [DW-1:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (wr_en_i) word_d = din_i;
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) word_q <= '0;
    else        word_q <= word_d;
  end

  assign word_o = word_q;
endmodule

module sp_32xn_ram #(
  parameter int DW = 4
) (
  input  logic          wclk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [4:0]    addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  localparam int DEPTH = 32;

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [DW-1:0]            dout_q, dout_d;

  // Each word owns its own flops so reset can clear the whole array at once.
  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    sp_32xn_ram_word #(.DW(DW)) u_word (
      .wclk    (wclk),
      .rst_n   (rst_n),
      .wr_en_i (we && (addr == 5'(w))),
      .din_i   (din),
      .word_o  (mem[w])
    );
  end

  // Read-first: the output register samples the pre-write contents.
  assign dout_d = mem[addr];

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) dout_q <= '0;
    else        dout_q <= dout_d;
  end

  assign dout = dout_q;
endmodule

// File: tb/tb_sp_32xn_ram.sv
// Directed, table-driven bench for sp_32xn_ram at DW=4 and DW=8.
module tb_sp_32xn_ram;
  logic       wclk = 1'b0;
  logic       rst_n;
  logic       we;
  logic [4:0] addr;
  logic [3:0] din4;
  logic [7:0] din8;
  logic [3:0] dout4;
  logic [7:0] dout8;

  int tests = 0;
  int fails = 0;

  always #5 wclk = ~wclk;

  sp_32xn_ram #(.DW(4)) u_dut4 (
    .wclk(wclk), .rst_n(rst_n), .we(we), .addr(addr), .din(din4), .dout(dout4)
  );
  sp_32xn_ram #(.DW(8)) u_dut8 (
    .wclk(wclk), .rst_n(rst_n), .we(we), .addr(addr), .din(din8), .dout(dout8)
  );

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [3:0] din;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change between edges; dout is sampled 1 time unit after the edge.
  task automatic cycle(input logic w, input logic [4:0] a, input logic [7:0] d);
    we   = w;
    addr = a;
    din4 = d[3:0];
    din8 = d;
    @(posedge wclk);
    #1;
  endtask

  function automatic vec_t mk(input logic w, input logic [4:0] a,
                              input logic [3:0] d, input logic [3:0] e);
    vec_t v;
    v.we = w; v.addr = a; v.din = d; v.exp = e;
    return v;
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] model [4];
    logic [7:0] rd0, rd31;
    logic [3:0] iv;
    logic [3:0] rnd;

    // write 5,9,C,F to 0..3; read back; collision on addr 2; write-disable
    vecs[0]  = mk(1, 0, 4'h5, 4'h0);
    vecs[1]  = mk(1, 1, 4'h9, 4'h0);
    vecs[2]  = mk(1, 2, 4'hC, 4'h0);
    vecs[3]  = mk(1, 3, 4'hF, 4'h0);
    vecs[4]  = mk(0, 0, 4'h0, 4'h5);
    vecs[5]  = mk(0, 1, 4'h0, 4'h9);
    vecs[6]  = mk(0, 2, 4'h0, 4'hC);
    vecs[7]  = mk(0, 3, 4'h0, 4'hF);
    vecs[8]  = mk(1, 2, 4'h3, 4'hC);
    vecs[9]  = mk(1, 2, 4'h7, 4'h3);
    vecs[10] = mk(0, 2, 4'h0, 4'h7);
    vecs[11] = mk(0, 0, 4'h6, 4'h5);
    vecs[12] = mk(0, 1, 4'hB, 4'h9);
    vecs[13] = mk(0, 2, 4'h1, 4'h7);
    vecs[14] = mk(0, 3, 4'hE, 4'hF);

    rst_n = 1'b0; we = 1'b0; addr = '0; din4 = '0; din8 = '0;
    repeat (3) @(posedge wclk);
    #1;
    chk("reset_dout4", {4'h0, dout4}, 8'h00);
    chk("reset_dout8", dout8, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].we, vecs[i].addr, {4'h0, vecs[i].din});
      chk($sformatf("vec%0d", i), {4'h0, dout4}, {4'h0, vecs[i].exp});
    end

    model[0] = 4'h5; model[1] = 4'h9; model[2] = 4'h7; model[3] = 4'hF;
    for (int i = 0; i < 16; i++) begin
      iv  = 4'(i);
      rnd = 4'($urandom_range(1, 15));
      cycle(~iv[2], {3'b0, iv[1:0]}, {4'h0, rnd});
      chk($sformatf("alt%0d", i), {4'h0, dout4}, {4'h0, model[iv[1:0]]});
      if (!iv[2]) model[iv[1:0]] = rnd;
    end

    for (int a = 0; a < 32; a++) cycle(1, 5'(a), 8'(a) ^ 8'h15);
    for (int a = 0; a < 32; a++) begin
      cycle(0, 5'(a), 8'h00);
      chk($sformatf("full%0d", a), dout8, 8'(a) ^ 8'h15);
      if (a == 0)  rd0  = dout8;
      if (a == 31) rd31 = dout8;
    end
    tests++;
    if (rd0 === rd31) begin
      fails++;
      $display("FAIL alias_0_31: got 0x%0h at both ends expected distinct words", rd0);
    end

    cycle(1, 3, 8'h0A);
    cycle(0, 3, 8'h00);
    chk("pre_reset_rd", {4'h0, dout4}, 8'h0A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dout4", {4'h0, dout4}, 8'h00);
    chk("async_rst_dout8", dout8, 8'h00);
    cycle(1, 5, 8'h04);
    chk("rst_hold_dout", {4'h0, dout4}, 8'h00);
    rst_n = 1'b1;
    cycle(0, 3, 8'h00);
    chk("post_rst_addr3", {4'h0, dout4}, 8'h00);
    cycle(0, 5, 8'h00);
    chk("post_rst_addr5", {4'h0, dout4}, 8'h00);
    cycle(0, 31, 8'h00);
    chk("post_rst_addr31_dw8", dout8, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
